laser_pool: RTL and testbench

Player-side projectile manager: launches lasers from the ship on the fire button, moves them up the screen once per frame, draws them, and detects pixel-coincidence with asteroid sprites. It drives the per-asteroid `shot` strobes, so it is the initiator of the hit interface that asteroid instances consume. It sits between the input/ship logic and the asteroid array, and its `drawing`/`pixel` outputs feed the top-level colour mux.

---
 rtl/game_pkg.sv | 14 +
 rtl/laser_slot.sv | 83 ++++++++
 rtl/laser_pool.sv | 137 +++++++++++++
 tb/tb_laser_pool.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types and constants: laser slot states, laser colour and the
// default screen coordinate width.
package game_pkg;

    localparam int unsigned SCREEN_CORDW = 16;
    localparam logic [3:0]  LASER_COLOR  = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        SPENT
    } laser_state_t;

endpackage

// File: rtl/laser_slot.sv
// One projectile: state, position, once-per-frame motion and the
// combinational "covers the current pixel" compare.
module laser_slot
    import game_pkg::*;
#(
    parameter int unsigned CORDW       = 16,
    parameter int unsigned LASER_W     = 2,
    parameter int unsigned LASER_H     = 8,
    parameter int unsigned LASER_SPEED = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame,
    input  logic             launch,
    input  logic [CORDW-1:0] launch_x,
    input  logic [CORDW-1:0] launch_y,
    input  logic             spent,
    input  logic [CORDW-1:0] screen_x,
    input  logic [CORDW-1:0] screen_y,
    output laser_state_t     state,
    output logic             covers
);

    localparam logic [CORDW-1:0] SPEED = CORDW'(LASER_SPEED);

    laser_state_t     state_q, state_d;
    logic [CORDW-1:0] x_q, x_d;
    logic [CORDW-1:0] y_q, y_d;
    logic [CORDW:0]   x_end, y_end;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        // A hit wins over the frame update so a spent laser never moves on.
        if (spent && state_q == FLYING) begin
            state_d = SPENT;
        end else if (frame) begin
            case (state_q)
                SPENT: state_d = IDLE;
                FLYING: begin
                    if (y_q < SPEED) begin
                        state_d = IDLE;
                    end else begin
                        y_d = y_q - SPEED;
                    end
                end
                IDLE: begin
                    if (launch) begin
                        state_d = FLYING;
                        x_d     = launch_x;
                        y_d     = launch_y;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // One extra bit keeps the far edge from wrapping near the top of the range.
    always_comb begin
        x_end  = {1'b0, x_q} + (CORDW + 1)'(LASER_W);
        y_end  = {1'b0, y_q} + (CORDW + 1)'(LASER_H);
        covers = (state_q == FLYING)
                 && (screen_x >= x_q) && ({1'b0, screen_x} < x_end)
                 && (screen_y >= y_q) && ({1'b0, screen_y} < y_end);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/laser_pool.sv
// Player laser manager: fire synchroniser, cooldown, slot allocation, drawing
// and asteroid collision. Define LASER_AUTOFIRE_EN to fire on the held level.
module laser_pool
    import game_pkg::*;
#(
    parameter int unsigned LASER_COUNT     = 4,
    parameter int unsigned ASTEROID_COUNT  = 10,
    parameter int unsigned H_RES           = 640,
    parameter int unsigned V_RES           = 480,
    parameter int unsigned SCREEN_CORDW    = game_pkg::SCREEN_CORDW,
    parameter int unsigned COLR_BITS       = 4,
    parameter int unsigned LASER_W         = 2,
    parameter int unsigned LASER_H         = 8,
    parameter int unsigned LASER_SPEED     = 8,
    parameter int unsigned COOLDOWN_FRAMES = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame,
    input  logic                      fire,
    input  logic [SCREEN_CORDW-1:0]   ship_x,
    input  logic [SCREEN_CORDW-1:0]   ship_y,
    input  logic [SCREEN_CORDW-1:0]   screen_x,
    input  logic [SCREEN_CORDW-1:0]   screen_y,
    input  logic [ASTEROID_COUNT-1:0] target_drawing,
    output logic [ASTEROID_COUNT-1:0] shot,
    output logic                      hit,
    output logic                      drawing,
    output logic [COLR_BITS-1:0]      pixel
);

    localparam int unsigned CD_W      = $clog2(COOLDOWN_FRAMES + 1);
    localparam int unsigned MIN_CORDW = $clog2((H_RES > V_RES ? H_RES : V_RES) + 1);

    if (SCREEN_CORDW < MIN_CORDW) begin : g_cordw_check
        $error("SCREEN_CORDW is too narrow for the screen resolution");
    end

    logic [1:0]                fire_sync_q, fire_sync_d;
    logic                      fire_prev_q, fire_prev_d;
    logic                      fire_set;
    logic                      pending_q, pending_d;
    logic [CD_W-1:0]           cooldown_q, cooldown_d;
    logic [ASTEROID_COUNT-1:0] shot_mask_q, shot_mask_d;
    logic [ASTEROID_COUNT-1:0] shot_q, shot_d;
    logic [ASTEROID_COUNT-1:0] cand;
    logic                      hit_q, hit_d;
    logic [LASER_COUNT-1:0]    cov_q, cov_d;
    logic [LASER_COUNT-1:0]    covers, idle, launch_vec, spent_vec;
    logic                      launch_ok, collide;
    logic [SCREEN_CORDW-1:0]   launch_y;

    for (genvar i = 0; i < LASER_COUNT; i++) begin : g_slot
        laser_state_t state;

        laser_slot #(
            .CORDW       (SCREEN_CORDW),
            .LASER_W     (LASER_W),
            .LASER_H     (LASER_H),
            .LASER_SPEED (LASER_SPEED)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .frame    (frame),
            .launch   (launch_vec[i]),
            .launch_x (ship_x),
            .launch_y (launch_y),
            .spent    (spent_vec[i]),
            .screen_x (screen_x),
            .screen_y (screen_y),
            .state    (state),
            .covers   (covers[i])
        );

        assign idle[i] = (state == IDLE);
    end

    always_comb begin
        fire_sync_d = {fire_sync_q[0], fire};
        fire_prev_d = fire_sync_q[1];
`ifdef LASER_AUTOFIRE_EN
        fire_set    = fire_sync_q[1];
`else
        fire_set    = fire_sync_q[1] & ~fire_prev_q;
`endif

        // Idle-ness is taken before this pulse, so a slot freed now waits a frame.
        launch_ok  = frame & pending_q & (cooldown_q == '0) & (|idle);
        launch_vec = launch_ok ? (idle & (~idle + LASER_COUNT'(1))) : '0;
        launch_y   = ship_y - SCREEN_CORDW'(LASER_H);

        cooldown_d = cooldown_q;
        if (launch_ok) begin
            cooldown_d = CD_W'(COOLDOWN_FRAMES);
        end else if (frame && cooldown_q != '0) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end
        pending_d = (pending_q & ~launch_ok) | fire_set;

        // Lowest covering slot and lowest unmasked target win.
        cand        = target_drawing & ~shot_mask_q;
        collide     = (|cov_q) & (|cand);
        spent_vec   = collide ? (cov_q & (~cov_q + LASER_COUNT'(1))) : '0;
        shot_d      = collide ? (cand & (~cand + ASTEROID_COUNT'(1))) : '0;
        hit_d       = collide;
        shot_mask_d = (frame ? '0 : shot_mask_q) | shot_d;
        cov_d       = covers & ~spent_vec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_sync_q <= '0;
            fire_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            cooldown_q  <= '0;
            shot_mask_q <= '0;
            shot_q      <= '0;
            hit_q       <= 1'b0;
            cov_q       <= '0;
        end else begin
            fire_sync_q <= fire_sync_d;
            fire_prev_q <= fire_prev_d;
            pending_q   <= pending_d;
            cooldown_q  <= cooldown_d;
            shot_mask_q <= shot_mask_d;
            shot_q      <= shot_d;
            hit_q       <= hit_d;
            cov_q       <= cov_d;
        end
    end

    assign shot    = shot_q;
    assign hit     = hit_q;
    assign drawing = |cov_q;
    assign pixel   = drawing ? COLR_BITS'(LASER_COLOR) : '0;

endmodule

// File: tb/tb_laser_pool.sv
// Self-checking bench for laser_pool: directed probe tables and sequences plus
// a randomized run against a per-clock behavioural model.
module tb_laser_pool;

    localparam int NL    = 4;
    localparam int NA    = 10;
    localparam int LW    = 2;
    localparam int LH    = 8;
    localparam int SPEED = 8;
    localparam int COOL  = 12;
    localparam int S_IDLE = 0, S_FLY = 1, S_SPENT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame = 1'b0;
    logic          fire = 1'b0;
    logic [15:0]   ship_x = '0, ship_y = '0, screen_x = '0, screen_y = '0;
    logic [NA-1:0] target_drawing = '0;
    logic [NA-1:0] shot;
    logic          hit, drawing;
    logic [3:0]    pixel;

    int n_cmp = 0;
    int n_bad = 0;

    laser_pool #(
        .LASER_COUNT     (NL),
        .ASTEROID_COUNT  (NA),
        .H_RES           (640),
        .V_RES           (480),
        .SCREEN_CORDW    (16),
        .COLR_BITS       (4),
        .LASER_W         (LW),
        .LASER_H         (LH),
        .LASER_SPEED     (SPEED),
        .COOLDOWN_FRAMES (COOL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame          (frame),
        .fire           (fire),
        .ship_x         (ship_x),
        .ship_y         (ship_y),
        .screen_x       (screen_x),
        .screen_y       (screen_y),
        .target_drawing (target_drawing),
        .shot           (shot),
        .hit            (hit),
        .drawing        (drawing),
        .pixel          (pixel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int            m_st [NL];
    int            m_x  [NL];
    int            m_y  [NL];
    bit            m_cov[NL];
    bit            m_f1, m_f2, m_f3, m_pend;
    int            m_cd;
    bit [NA-1:0]   m_mask, e_shot;
    bit            e_hit, e_draw;

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_st[i] = S_IDLE; m_x[i] = 0; m_y[i] = 0; m_cov[i] = 0;
        end
        m_f1 = 0; m_f2 = 0; m_f3 = 0; m_pend = 0; m_cd = 0;
        m_mask = '0; e_shot = '0; e_hit = 0; e_draw = 0;
    endtask

    task automatic model_step(input bit fr, input bit fi, input int shx, input int shy,
                              input int scx, input int scy, input bit [NA-1:0] tgt);
        int          win, tw, ls;
        bit          set;
        bit [NA-1:0] cand;
        bit          nc[NL];
`ifdef LASER_AUTOFIRE_EN
        set = m_f2;
`else
        set = m_f2 && !m_f3;
`endif
        m_f3 = m_f2; m_f2 = m_f1; m_f1 = fi;
        cand = tgt & ~m_mask;
        win = -1; tw = -1;
        for (int i = NL - 1; i >= 0; i--) if (m_cov[i]) win = i;
        for (int t = NA - 1; t >= 0; t--) if (cand[t]) tw = t;
        e_shot = '0; e_hit = 0;
        if (win >= 0 && tw >= 0) begin
            e_shot[tw] = 1'b1; e_hit = 1;
        end else begin
            win = -1;
        end
        for (int i = 0; i < NL; i++)
            nc[i] = (m_st[i] == S_FLY) && scx >= m_x[i] && scx < m_x[i] + LW
                    && scy >= m_y[i] && scy < m_y[i] + LH && i != win;
        ls = -1;
        if (fr && m_pend && m_cd == 0)
            for (int i = NL - 1; i >= 0; i--) if (m_st[i] == S_IDLE) ls = i;
        for (int i = 0; i < NL; i++) begin
            if (i == win && m_st[i] == S_FLY) begin
                m_st[i] = S_SPENT;
            end else if (fr) begin
                if (m_st[i] == S_SPENT) m_st[i] = S_IDLE;
                else if (m_st[i] == S_FLY) begin
                    if (m_y[i] < SPEED) m_st[i] = S_IDLE;
                    else m_y[i] = m_y[i] - SPEED;
                end else if (i == ls) begin
                    m_st[i] = S_FLY; m_x[i] = shx; m_y[i] = (shy - LH) & 16'hFFFF;
                end
            end
        end
        if (ls >= 0) m_cd = COOL;
        else if (fr && m_cd > 0) m_cd--;
        m_pend = (m_pend && ls < 0) || set;
        m_mask = (fr ? '0 : m_mask) | e_shot;
        e_draw = 0;
        for (int i = 0; i < NL; i++) begin
            m_cov[i] = nc[i];
            e_draw |= nc[i];
        end
    endtask

    // Continuous comparison against the model, sampled 1 time unit after each edge.
    always @(posedge clk) begin
        logic          r, fr, fi;
        logic [15:0]   a, b, c, d;
        logic [NA-1:0] t;
        r = rst; fr = frame; fi = fire; a = ship_x; b = ship_y;
        c = screen_x; d = screen_y; t = target_drawing;
        #1;
        if (!r) begin
            model_reset();
        end else begin
            model_step(fr, fi, int'(a), int'(b), int'(c), int'(d), t);
            check("model_shot", 64'(shot), 64'(e_shot));
            check("model_hit", 64'(hit), 64'(e_hit));
            check("model_drawing", 64'(drawing), 64'(e_draw));
            check("model_pixel", 64'(pixel), e_draw ? 64'(game_pkg::LASER_COLOR) : 64'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; frame = 1'b0; fire = 1'b0; target_drawing = '0;
        #1 check("reset_outputs", 64'({shot, hit, drawing, pixel}), 64'd0);
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic press();
        fire = 1'b1; tick(4); fire = 1'b0; tick(1);
    endtask

    task automatic frame_step();
        frame = 1'b1; tick(1); frame = 1'b0; tick(3);
    endtask

    task automatic probe(input string name, input int x, input int y, input bit exp);
        screen_x = 16'(x); screen_y = 16'(y);
        tick(1);
        check(name, 64'(drawing), 64'(exp));
        check({name, "_pix"}, 64'(pixel), exp ? 64'(game_pkg::LASER_COLOR) : 64'd0);
    endtask

    typedef struct {
        int frames;
        int sx;
        int sy;
        bit draw;
    } probe_t;

    probe_t tbl[11];

    initial begin
        int       found;
        bit       seen;
        int       pick;
        logic [63:0] got, want;

        tbl = '{'{0, 320, 392, 1}, '{0, 321, 399, 1}, '{0, 319, 395, 0},
                '{0, 322, 395, 0}, '{0, 320, 391, 0}, '{0, 321, 400, 0},
                '{3, 320, 368, 1}, '{0, 321, 375, 1}, '{0, 320, 376, 0},
                '{0, 320, 367, 0}, '{0, 322, 368, 0}};

        // Launch from (320,400) and track the laser through the probe table.
        do_reset();
        ship_x = 320; ship_y = 400;
        press();
        frame_step();
        foreach (tbl[k]) begin
            repeat (tbl[k].frames) frame_step();
            probe($sformatf("table_%0d", k), tbl[k].sx, tbl[k].sy, tbl[k].draw);
        end

        // Laser at y=5 leaves the top on the next frame.
        do_reset();
        ship_x = 100; ship_y = 13;
        press();
        frame_step();
        probe("offtop_before", 100, 5, 1);
        probe("offtop_before_edge", 101, 12, 1);
        frame_step();
        probe("offtop_after", 100, 5, 0);
        seen = 0;
        for (int f = 0; f < 3; f++) begin
            frame_step();
            for (int y = 0; y < 16; y++) begin
                screen_x = 100; screen_y = 16'(y); tick(1);
                if (drawing) seen = 1;
            end
        end
        check("offtop_never_again", 64'(seen), 64'd0);

        // Single hit on target 3.
        do_reset();
        ship_x = 100; ship_y = 200;
        press();
        frame_step();
        probe("hit_covering", 100, 192, 1);
        target_drawing = 10'b0000001000;
        tick(1);
        check("hit_shot", 64'(shot), 64'(10'b0000001000));
        check("hit_hit", 64'(hit), 64'd1);
        check("hit_stops_drawing", 64'(drawing), 64'd0);
        tick(1);
        check("hit_shot_one_clk", 64'({shot, hit}), 64'd0);
        seen = 0;
        repeat (5) begin
            tick(1);
            if (shot != '0 || hit) seen = 1;
        end
        check("hit_no_repeat", 64'(seen), 64'd0);
        target_drawing = '0;

        // Cooldown: second press two frames after the first launch.
        do_reset();
        ship_x = 50; ship_y = 300; screen_x = 50; screen_y = 292;
        press();
        frame_step();
        check("cool_first_launch", 64'(drawing), 64'd1);
        found = 0;
        for (int p = 1; p <= 30 && found == 0; p++) begin
            frame_step();
            if (drawing) found = p;
            if (p == 2) press();
        end
        check("cool_second_launch_frame", 64'(found), 64'd13);

        // Same-frame mask: laser A at y=188, laser B at y=292.
        probe("mask_cover_a", 50, 188, 1);
        target_drawing = 10'b0000001000;
        tick(1);
        check("mask_first_shot", 64'(shot), 64'(10'b0000001000));
        target_drawing = '0;
        probe("mask_cover_b", 50, 292, 1);
        target_drawing = 10'b0000001000;
        tick(1);
        check("mask_blocks_repeat", 64'({shot, hit}), 64'd0);
        target_drawing = 10'b0000101000;
        tick(1);
        check("mask_next_target", 64'(shot), 64'(10'b0000100000));
        target_drawing = '0;

        // Fill all four slots, then press: launch waits for slot 0 to leave.
        do_reset();
        ship_x = 200; ship_y = 460; screen_x = 200; screen_y = 452;
        for (int k = 0; k < NL; k++) begin
            press();
            frame_step();
            check($sformatf("full_launch_%0d", k), 64'(drawing), 64'd1);
            if (k < NL - 1) repeat (COOL) frame_step();
        end
        press();
        found = 0;
        for (int p = 1; p <= 30 && found == 0; p++) begin
            frame_step();
            if (drawing) found = p;
        end
        check("full_relaunch_frame", 64'(found), 64'd19);

`ifdef LASER_AUTOFIRE_EN
        do_reset();
        ship_x = 300; ship_y = 460; screen_x = 300; screen_y = 452;
        fire = 1'b1; tick(4);
        got = '0;
        for (int f = 1; f <= 40; f++) begin
            frame_step();
            if (drawing) got[f] = 1'b1;
        end
        fire = 1'b0;
        want = '0; want[1] = 1'b1; want[14] = 1'b1; want[27] = 1'b1; want[40] = 1'b1;
        check("autofire_frames", got, want);
`else
        got = '0; want = '0;
`endif

        // Randomized run against the model, with one asynchronous reset mid-stream.
        do_reset();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            frame = (frame == 1'b0) && ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) fire = ~fire;
            if (frame) begin
                ship_x = 16'($urandom_range(0, 638));
                ship_y = 16'($urandom_range(8, 479));
            end
            pick = int'($urandom_range(0, 2 * NL - 1));
            if (pick < NL && m_st[pick] == S_FLY) begin
                screen_x = 16'(m_x[pick] + int'($urandom_range(0, 2)));
                screen_y = 16'(m_y[pick] + int'($urandom_range(0, 9)) - 1);
            end else begin
                screen_x = 16'($urandom_range(0, 639));
                screen_y = 16'($urandom_range(0, 479));
            end
            target_drawing = ($urandom_range(0, 2) == 0) ? NA'($urandom & $urandom) : '0;
            if (cyc == 3000) begin
                rst = 1'b0;
                #1 check("async_reset_clears", 64'({shot, hit, drawing, pixel}), 64'd0);
            end
            if (cyc == 3002) rst = 1'b1;
            tick(1);
        end
        frame = 1'b0; target_drawing = '0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
